auto_gain_ctrl: RTL and testbench

- Closed-loop partner of the 48-bit digital gain stage. It watches the 48-bit peak magnitude (`max`) that the gain stage reports and computes the `scaled_coeff` bit-window shift that the gain stage consumes.
- Per window of AVG_FRAMES spectra, it finds the peak's leading-one position and picks the shift that fits the peak into a 16-bit signed output with HEADROOM spare bits.
- Attack is fast, decay is slow with hysteresis, and a manual override is provided.

---
 rtl/auto_gain_ctrl_pkg.sv | 24 ++
 rtl/auto_gain_ctrl_lead_one_48.sv | 20 ++
 rtl/auto_gain_ctrl.sv | 125 ++++++++++++
 tb/tb_auto_gain_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/auto_gain_ctrl_pkg.sv
// Shared types and constants for the automatic gain controller.
// Imported by the controller top and its leading-one encoder.
package auto_gain_ctrl_pkg;

  localparam int DATA_W      = 48;
  localparam int OUT_W       = 16;
  localparam int OUT_MAG_MSB = 14;
  localparam int COEFF_W     = 6;
  localparam int IDX_W       = 6;

  typedef enum logic [1:0] {
    S_ACC = 2'd0,
    S_LOD = 2'd1,
    S_DEC = 2'd2
  } agc_state_e;

  function automatic logic [DATA_W-1:0] umax(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/auto_gain_ctrl_lead_one_48.sv
// Combinational priority encoder: index of the highest set bit
// of a 48-bit word, plus a flag for the all-zero word.
module lead_one_48
  import auto_gain_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] data_i,
  output logic [IDX_W-1:0]  idx_o,
  output logic              zero_o
);

  // Scan upward so the last (highest) set bit wins.
  always_comb begin
    idx_o  = '0;
    zero_o = ~|data_i;
    for (int i = 0; i < DATA_W; i++) begin
      if (data_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/auto_gain_ctrl.sv
// Windowed peak tracker that picks the gain-stage bit-window shift:
// fast attack, slow hysteretic decay, manual override.
module auto_gain_ctrl
  import auto_gain_ctrl_pkg::*;
#(
  parameter int BITWIDTH   = 7,
  parameter int FFT_POINT  = 512,
  parameter int AVG_FRAMES = 4,
  parameter int HEADROOM   = 1,
  parameter int HYST       = 2,
  parameter int INIT_COEFF = 16,
  parameter int MAX_COEFF  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en_sync_in,
  input  logic [BITWIDTH+1:0]   cnt_sync_in,
  input  logic [DATA_W-1:0]     max_in,
  input  logic                  man_en,
  input  logic [COEFF_W-1:0]    man_coeff,
  output logic [OUT_W-1:0]      scaled_coeff,
  output logic                  coeff_valid,
  output logic                  clip_flag,
  output logic [DATA_W-1:0]     win_peak
);

  localparam int FW = (AVG_FRAMES > 1) ? $clog2(AVG_FRAMES) : 1;
  localparam logic [BITWIDTH+1:0] LAST_BIN =
    (BITWIDTH+2)'(FFT_POINT - 1);
  localparam logic [FW-1:0] LAST_FRM = FW'(AVG_FRAMES - 1);
  localparam logic [COEFF_W-1:0] MAXC  = COEFF_W'(MAX_COEFF);
  localparam logic [COEFF_W-1:0] INITC = COEFF_W'(INIT_COEFF);
  localparam logic [COEFF_W-1:0] HYSTC = COEFF_W'(HYST);
  localparam logic signed [7:0] OFS  = 8'(HEADROOM - OUT_MAG_MSB);
  localparam logic signed [7:0] MAXS = 8'(MAX_COEFF);

  logic [DATA_W-1:0]  peak_q, win_q, pk_max;
  logic [FW-1:0]      frm_q;
  logic [COEFF_W-1:0] coeff_q, tgt_q, tgt_d, next_d, man_sat;
  logic               valid_q, clip_q;
  agc_state_e         st_q;
  logic               fe, we;
  logic [IDX_W-1:0]   lo_idx;
  logic               lo_zero;
  logic signed [7:0]  t_raw;

  assign fe     = en_sync_in && (cnt_sync_in == LAST_BIN);
  assign we     = fe && (frm_q == LAST_FRM);
  assign pk_max = umax(peak_q, max_in);

  lead_one_48 u_lod (
    .data_i (win_q),
    .idx_o  (lo_idx),
    .zero_o (lo_zero)
  );

  // Target shift from the leading-one position, clamped to range.
  always_comb begin
    t_raw = $signed({2'b00, lo_idx}) + OFS;
    tgt_d = '0;
    if (lo_zero || t_raw < 0) tgt_d = '0;
    else if (t_raw > MAXS)    tgt_d = MAXC;
    else                      tgt_d = t_raw[COEFF_W-1:0];
  end

  // Attack jumps straight up; decay steps down only past hysteresis.
  always_comb begin
    next_d  = coeff_q;
    man_sat = (man_coeff > MAXC) ? MAXC : man_coeff;
    if (tgt_q > coeff_q)
      next_d = tgt_q;
    else if ((coeff_q - tgt_q) >= HYSTC)
      next_d = coeff_q - 1'b1;
  end

  // Running window peak and frame counting on valid beats only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
      win_q  <= '0;
      frm_q  <= '0;
    end else if (en_sync_in) begin
      peak_q <= we ? '0 : pk_max;
      if (we) win_q <= pk_max;
      if (fe) frm_q <= (frm_q == LAST_FRM) ? '0 : frm_q + 1'b1;
    end
  end

  // Evaluation FSM with registered coefficient and status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_ACC;
      tgt_q   <= '0;
      coeff_q <= INITC;
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      clip_q  <= 1'b0;
      unique case (st_q)
        S_ACC: if (we) st_q <= S_LOD;
        S_LOD: begin
          tgt_q <= tgt_d;
          st_q  <= S_DEC;
        end
        S_DEC: begin
          st_q <= S_ACC;
          if (!man_en) begin
            coeff_q <= next_d;
            valid_q <= 1'b1;
            clip_q  <= tgt_q > coeff_q;
          end
        end
        default: st_q <= S_ACC;
      endcase
      if (man_en) coeff_q <= man_sat;
    end
  end

  assign scaled_coeff = {(OUT_W-COEFF_W)'(0), coeff_q};
  assign coeff_valid  = valid_q;
  assign clip_flag    = clip_q;
  assign win_peak     = win_q;

endmodule

// File: tb/tb_auto_gain_ctrl.sv
// Randomized bench for auto_gain_ctrl against a window-level
// reference model, plus directed attack/decay/override/reset cases.
module tb_auto_gain_ctrl;

  localparam int NPT  = 512;
  localparam int NFR  = 4;
  localparam int HR   = 1;
  localparam int HYS  = 2;
  localparam int INIT = 16;
  localparam int MAXC = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [8:0]  cnt;
  logic [47:0] mx;
  logic        man;
  logic [5:0]  mc;
  logic [15:0] scaled_coeff;
  logic        coeff_valid, clip_flag;
  logic [47:0] win_peak;

  int n_vec = 0;
  int n_err = 0;

  int          m_cur, m_tgt, m_frm;
  logic [47:0] m_pk, m_wp;
  longint      edge_n, m_due;
  bit          m_valid, m_clip;

  always #5 clk = ~clk;

  auto_gain_ctrl #(
    .BITWIDTH   (7),
    .FFT_POINT  (NPT),
    .AVG_FRAMES (NFR),
    .HEADROOM   (HR),
    .HYST       (HYS),
    .INIT_COEFF (INIT),
    .MAX_COEFF  (MAXC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en_sync_in   (en),
    .cnt_sync_in  (cnt),
    .max_in       (mx),
    .man_en       (man),
    .man_coeff    (mc),
    .scaled_coeff (scaled_coeff),
    .coeff_valid  (coeff_valid),
    .clip_flag    (clip_flag),
    .win_peak     (win_peak)
  );

  task automatic chk(input string tag, input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, act, exp, $time);
    end
  endtask

  function automatic int target_of(input logic [47:0] v);
    int p, t;
    if (v == 0) return 0;
    p = 0;
    for (int i = 0; i < 48; i++) if (v[i]) p = i;
    t = p - 14 + HR;
    if (t < 0) t = 0;
    if (t > MAXC) t = MAXC;
    return t;
  endfunction

  task automatic model_reset();
    m_cur = INIT; m_tgt = 0; m_frm = 0;
    m_pk = '0; m_wp = '0; m_due = -1;
    m_valid = 0; m_clip = 0;
  endtask

  task automatic model_edge();
    logic [47:0] pk;
    m_valid = 0;
    m_clip  = 0;
    if (man) begin
      m_cur = (int'(mc) > MAXC) ? MAXC : int'(mc);
    end else if (edge_n == m_due) begin
      m_valid = 1;
      m_clip  = m_tgt > m_cur;
      if (m_tgt > m_cur) m_cur = m_tgt;
      else if (m_cur - m_tgt >= HYS) m_cur = m_cur - 1;
    end
    if (en) begin
      pk = (mx > m_pk) ? mx : m_pk;
      m_pk = pk;
      if (cnt == 9'(NPT - 1)) begin
        if (m_frm == NFR - 1) begin
          m_wp  = pk;
          m_tgt = target_of(pk);
          m_due = edge_n + 2;
          m_pk  = '0;
          m_frm = 0;
        end else begin
          m_frm++;
        end
      end
    end
    edge_n++;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    chk("scaled", 64'(scaled_coeff), 64'(m_cur));
    chk("valid", 64'(coeff_valid), 64'(m_valid));
    chk("clip", 64'(clip_flag), 64'(m_clip));
    chk("win_peak", 64'(win_peak), 64'(m_wp));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      en = 0; cnt = 9'($urandom); mx = '0;
      tick();
    end
  endtask

  // mode 0: constant value, 1: random, 2: random with override noise
  task automatic run_window(input int mode, input logic [47:0] v);
    int sh;
    logic [63:0] r;
    sh = $urandom_range(0, 47);
    for (int f = 0; f < NFR; f++) begin
      for (int b = 0; b < NPT; b++) begin
        while ($urandom_range(0, 9) == 0) begin
          en = 0; cnt = 9'($urandom);
          mx = {$urandom, $urandom};
          tick();
        end
        if (mode == 2 && $urandom_range(0, 399) == 0) begin
          man = ~man; mc = 6'($urandom);
        end
        r  = {$urandom, $urandom};
        en = 1; cnt = 9'(b);
        mx = (mode == 0) ? v
           : (r[47:0] >> (sh + $urandom_range(0, 3)));
        tick();
      end
    end
  endtask

  initial begin
    edge_n = 0;
    en = 0; cnt = '0; mx = '0; man = 0; mc = '0;
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_coeff", 64'(scaled_coeff), 64'(INIT));
    chk("rst_valid", 64'(coeff_valid), 64'd0);
    chk("rst_peak", 64'(win_peak), 64'd0);
    rst = 0;

    run_window(0, 48'h1 << 30);
    idle(2);
    chk("att_coeff", 64'(scaled_coeff), 64'd17);
    chk("att_valid", 64'(coeff_valid), 64'd1);
    chk("att_clip", 64'(clip_flag), 64'd1);
    chk("att_peak", 64'(win_peak), 64'h4000_0000);

    for (int i = 0; i < 10; i++) begin
      run_window(0, 48'h1 << 20);
      idle(2);
      chk("dec_coeff", 64'(scaled_coeff),
          64'((17 - (i + 1) > 8) ? 17 - (i + 1) : 8));
      chk("dec_valid", 64'(coeff_valid), 64'd1);
      chk("dec_clip", 64'(clip_flag), 64'd0);
    end

    run_window(0, 48'h0);
    idle(2);
    chk("zero_coeff", 64'(scaled_coeff), 64'd7);
    chk("zero_peak", 64'(win_peak), 64'd0);

    run_window(0, 48'h1 << 47);
    idle(2);
    chk("sat_coeff", 64'(scaled_coeff), 64'd32);
    chk("sat_clip", 64'(clip_flag), 64'd1);

    idle(1);
    man = 1; mc = 6'd40;
    idle(1);
    chk("man_coeff", 64'(scaled_coeff), 64'd32);
    chk("man_valid", 64'(coeff_valid), 64'd0);
    idle(3);
    man = 0;
    run_window(0, 48'h1 << 30);
    idle(2);
    chk("rel_coeff", 64'(scaled_coeff), 64'd31);
    chk("rel_valid", 64'(coeff_valid), 64'd1);

    for (int b = 0; b < 300; b++) begin
      en = 1; cnt = 9'(b); mx = 48'h1 << 40;
      tick();
    end
    #3 rst = 1;
    #1;
    chk("arst_coeff", 64'(scaled_coeff), 64'(INIT));
    chk("arst_valid", 64'(coeff_valid), 64'd0);
    chk("arst_peak", 64'(win_peak), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("arst_hold", 64'(scaled_coeff), 64'(INIT));
    rst = 0;
    model_reset();
    run_window(0, 48'h1 << 30);
    idle(2);
    chk("post_coeff", 64'(scaled_coeff), 64'd17);
    chk("post_peak", 64'(win_peak), 64'h4000_0000);

    for (int w = 0; w < 5; w++) run_window(2, '0);
    man = 0;
    idle(4);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
